// File: rtl/la_nn_cmd_bridge.sv
`timescale 1ns/1ps
// la_nn_cmd_bridge
// Bridges firmware commands on the Caravel logic-analyzer probes to the NN core.
// It runs one req/ack transaction or a start pulse per strobe toggle.
// Read data, a done toggle and status flags are returned on the LA input probes.
// Optional build macro: LA_NN_TIMEOUT_EN adds a watchdog on the ISSUE state.
// The watchdog abandons a transaction after TIMEOUT_CYCLES unacknowledged cycles
// and raises the error flag (bit 66).
module la_nn_cmd_bridge #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic [127:0]      la_data_in,
    input  logic [127:0]      la_oenb,
    output logic [127:0]      la_data_out,
    output logic              nn_req,
    output logic              nn_we,
    output logic [ADDR_W-1:0] nn_addr,
    output logic [DATA_W-1:0] nn_wdata,
    input  logic [DATA_W-1:0] nn_rdata,
    input  logic              nn_ack,
    output logic              nn_start
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_START = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              strobe_q;
    logic              new_cmd;
    logic [1:0]        op_in;
    logic [DATA_W-1:0] rdata_q;
    logic              done_q;
    logic              ovr_q;
    logic              start_q;
    logic              tmo_hit;
    logic              err_flag;
    logic              unused_ok;

    assign op_in    = la_data_in[49:48];
    // A command is a change of the strobe bit, but only while firmware drives it.
    assign new_cmd  = !la_oenb[64] && (la_data_in[64] != strobe_q);
    assign nn_start = start_q;

    // Probe bits outside the command fields are deliberately ignored.
    assign unused_ok = ^{la_data_in[127:65], la_data_in[63:0],
                         la_oenb[127:65], la_oenb[63:0], 32'(TIMEOUT_CYCLES)};

    // State register
    always_ff @(posedge clock) begin
        if (!resetb) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode and NN request
    always_comb begin
        state_nxt = state;
        nn_req    = 1'b0;
        unique case (state)
            IDLE: begin
                if (new_cmd) begin
                    if (op_in == OP_WRITE || op_in == OP_READ) state_nxt = ISSUE;
                    else                                        state_nxt = DONE;
                end
            end
            ISSUE: begin
                nn_req = 1'b1;
                if (nn_ack || tmo_hit) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture, strobe tracking, overrun flag, read data and done toggle
    always_ff @(posedge clock) begin
        if (!resetb) begin
            strobe_q <= la_data_in[64];
            nn_we    <= 1'b0;
            nn_addr  <= '0;
            nn_wdata <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (!la_oenb[64]) strobe_q <= la_data_in[64];
            unique case (state)
                IDLE: begin
                    if (new_cmd) begin
                        nn_we    <= (op_in == OP_WRITE);
                        nn_addr  <= la_data_in[32 +: ADDR_W];
                        nn_wdata <= la_data_in[0 +: DATA_W];
                        start_q  <= (op_in == OP_START);
                        if (op_in == OP_NOP) ovr_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    // A toggle while busy is consumed and dropped; only the flag records it.
                    if (new_cmd) ovr_q <= 1'b1;
                    if (nn_ack && !nn_we) rdata_q <= nn_rdata;
                end
                DONE: begin
                    if (new_cmd) ovr_q <= 1'b1;
                    done_q <= ~done_q;
                end
                default: ;
            endcase
        end
    end

`ifdef LA_NN_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             err_q;

    // Expiry is the last unacknowledged ISSUE cycle, so nn_req is high exactly TIMEOUT_CYCLES cycles.
    assign tmo_hit  = (state == ISSUE) && !nn_ack && (tmo_cnt == TMO_LAST);
    assign err_flag = err_q;

    // Watchdog counter, held clear outside a transaction, and sticky error flag
    always_ff @(posedge clock) begin
        if (!resetb) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                tmo_cnt <= '0;
                if (new_cmd && op_in == OP_NOP) err_q <= 1'b0;
            end else if (state == ISSUE && !nn_ack) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (tmo_hit) err_q <= 1'b1;
        end
    end
`else
    assign tmo_hit  = 1'b0;
    assign err_flag = 1'b0;
`endif

    // Status word returned to firmware; unused probe bits read as zero
    always_comb begin
        la_data_out             = '0;
        la_data_out[DATA_W-1:0] = rdata_q;
        la_data_out[64]         = done_q;
        la_data_out[65]         = (state != IDLE);
        la_data_out[66]         = err_flag;
        la_data_out[67]         = ovr_q;
    end

endmodule

// File: tb/tb_la_nn_cmd_bridge.sv
`timescale 1ns/1ps
// Bench for la_nn_cmd_bridge: directed vector table, multi-cycle corner
// sequences and randomized commands against a transaction-level model.
module tb_la_nn_cmd_bridge;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_ST  = 2'b11;
`ifdef LA_NN_TIMEOUT_EN
    localparam int OVR_DLY = 6;
`else
    localparam int OVR_DLY = 10;
`endif

    logic         clock = 1'b0;
    logic         resetb = 1'b0;
    logic [127:0] la_data_in = '0;
    logic [127:0] la_oenb = '1;
    logic [127:0] la_data_out;
    logic         nn_req, nn_we, nn_start;
    logic         nn_ack = 1'b0;
    logic [15:0]  nn_addr;
    logic [31:0]  nn_wdata;
    logic [31:0]  nn_rdata = '0;

    int n_chk = 0;
    int n_fail = 0;

    // transaction-level model of the status the firmware sees
    logic [31:0] m_rdata = '0;
    logic        m_done = 1'b0;
    logic        m_ovr = 1'b0;
    logic        m_err = 1'b0;

    int r_req, r_start, r_lat, r_rises;
    bit r_attr;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr;
        logic [31:0] wdata;
        int          dly;
        logic [31:0] rd;
        int          exp_req;
        int          exp_start;
        int          exp_lat;
        logic [31:0] exp_rdata;
        logic        exp_done;
    } vec_t;
    vec_t vecs [6];

    la_nn_cmd_bridge #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .resetb(resetb), .la_data_in(la_data_in), .la_oenb(la_oenb),
        .la_data_out(la_data_out), .nn_req(nn_req), .nn_we(nn_we), .nn_addr(nn_addr),
        .nn_wdata(nn_wdata), .nn_rdata(nn_rdata), .nn_ack(nn_ack), .nn_start(nn_start)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one command by toggling the strobe and act as the NN core until done toggles.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wd,
                           input int dly, input logic [31:0] rd, input bit spur, input int inj_at);
        logic d0;
        logic prev_req;
        d0 = la_data_out[64];
        prev_req = 1'b0;
        r_req = 0; r_start = 0; r_lat = -1; r_rises = 0; r_attr = 1'b1;
        la_data_in[31:0]  = wd;
        la_data_in[47:32] = addr;
        la_data_in[49:48] = op;
        la_data_in[64]    = ~la_data_in[64];
        for (int cyc = 1; cyc <= 40 && r_lat < 0; cyc++) begin
            tick();
            if (nn_req) begin
                r_req++;
                if (!prev_req) r_rises++;
                if (nn_we !== (op == OP_WR) || nn_addr !== addr || nn_wdata !== wd) r_attr = 1'b0;
            end
            prev_req = nn_req;
            if (nn_start) r_start++;
            if (la_data_out[64] !== d0) r_lat = cyc;
            if (cyc == inj_at) la_data_in[64] = ~la_data_in[64];
            if (nn_req) begin
                nn_ack   = (r_req == dly);
                nn_rdata = (r_req == dly) ? rd : $urandom();
            end else begin
                nn_ack   = spur ? 1'($urandom_range(0, 1)) : 1'b0;
                nn_rdata = $urandom();
            end
        end
        nn_ack = 1'b0;
    endtask

    task automatic model_upd(input logic [1:0] op, input logic [31:0] rd, input bit inj, input bit tmo);
        if (op == OP_RD && !tmo) m_rdata = rd;
        m_done = ~m_done;
        if (op == OP_NOP) begin
            m_ovr = 1'b0;
            m_err = 1'b0;
        end
        if (inj) m_ovr = 1'b1;
        if (tmo) m_err = 1'b1;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".rdata"}, la_data_out[31:0], m_rdata);
        chk({tag, ".done"}, 32'(la_data_out[64]), 32'(m_done));
        chk({tag, ".busy"}, 32'(la_data_out[65]), 32'd0);
        chk({tag, ".err"}, 32'(la_data_out[66]), 32'(m_err));
        chk({tag, ".ovr"}, 32'(la_data_out[67]), 32'(m_ovr));
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] rrd;
        int          rdly;
        int          inj;
        int          cnt;
        logic        d0;
        bit          rw;

        //             op      addr      wdata         dly rd            req st lat rdata         done
        vecs[0] = '{OP_WR,  16'h0010, 32'hDEADBEEF, 3, 32'hBAD0BAD0, 3, 0, 5, 32'h00000000, 1'b1};
        vecs[1] = '{OP_RD,  16'h0020, 32'h00000000, 1, 32'h12345678, 1, 0, 3, 32'h12345678, 1'b0};
        vecs[2] = '{OP_ST,  16'h0030, 32'h0000AAAA, 1, 32'h0,        0, 1, 2, 32'h12345678, 1'b1};
        vecs[3] = '{OP_NOP, 16'h0000, 32'h00000000, 1, 32'h0,        0, 0, 2, 32'h12345678, 1'b0};
        vecs[4] = '{OP_WR,  16'hFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFF, 2, 0, 4, 32'h12345678, 1'b1};
        vecs[5] = '{OP_RD,  16'h0000, 32'h55555555, 5, 32'hA5A50F0F, 5, 0, 7, 32'hA5A50F0F, 1'b0};

        la_oenb[64]   = 1'b0;
        la_oenb[49:0] = '0;

        // reset
        resetb = 1'b0;
        tick(); tick();
        chk128("reset.la_data_out", la_data_out, 128'h0);
        chk("reset.nn_req", 32'(nn_req), 32'd0);
        chk("reset.nn_start", 32'(nn_start), 32'd0);
        chk("reset.nn_we", 32'(nn_we), 32'd0);
        chk("reset.nn_addr", 32'(nn_addr), 32'd0);
        chk("reset.nn_wdata", nn_wdata, 32'd0);
        resetb = 1'b1;
        tick();

        // directed vector table
        for (int i = 0; i < 6; i++) begin
            run_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].dly, vecs[i].rd, 1'b0, 0);
            chk($sformatf("vec%0d.req_cycles", i), r_req, vecs[i].exp_req);
            chk($sformatf("vec%0d.start_cycles", i), r_start, vecs[i].exp_start);
            chk($sformatf("vec%0d.done_latency", i), r_lat, vecs[i].exp_lat);
            chk($sformatf("vec%0d.req_attrs", i), 32'(r_attr), 32'd1);
            chk($sformatf("vec%0d.rdata", i), la_data_out[31:0], vecs[i].exp_rdata);
            chk($sformatf("vec%0d.done_bit", i), 32'(la_data_out[64]), 32'(vecs[i].exp_done));
            chk($sformatf("vec%0d.busy", i), 32'(la_data_out[65]), 32'd0);
            chk($sformatf("vec%0d.flags", i), 32'(la_data_out[67:66]), 32'd0);
            model_upd(vecs[i].op, vecs[i].rd, 1'b0, 1'b0);
        end

        // overrun: second toggle during a long READ, then a NOP clears the flag
        run_cmd(OP_RD, 16'h0040, 32'h0, OVR_DLY, 32'hCAFE0001, 1'b0, 4);
        chk("ovr.req_cycles", r_req, OVR_DLY);
        chk("ovr.req_pulses", r_rises, 1);
        chk("ovr.done_latency", r_lat, OVR_DLY + 2);
        model_upd(OP_RD, 32'hCAFE0001, 1'b1, 1'b0);
        chk_status("ovr");
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (nn_req) cnt++;
        end
        chk("ovr.no_second_txn", cnt, 0);
        run_cmd(OP_NOP, 16'h0, 32'h0, 1, 32'h0, 1'b0, 0);
        chk("ovr_clear.done_latency", r_lat, 2);
        model_upd(OP_NOP, 32'h0, 1'b0, 1'b0);
        chk_status("ovr_clear");

        // strobe ignored while firmware is not driving it
        la_oenb[64] = 1'b1;
        la_data_in[49:48] = OP_WR;
        d0 = la_data_out[64];
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            la_data_in[64] = ~la_data_in[64];
            tick();
            if (nn_req || nn_start || la_data_out[65]) cnt++;
            tick();
            if (nn_req || nn_start || la_data_out[65]) cnt++;
        end
        chk("oenb.no_activity", cnt, 0);
        chk("oenb.done_held", 32'(la_data_out[64]), 32'(d0));
        la_oenb[64] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (nn_req || la_data_out[65]) cnt++;
        end
        chk("oenb.release_quiet", cnt, 0);
        run_cmd(OP_RD, 16'h0123, 32'h0, 2, 32'h0BADF00D, 1'b0, 0);
        chk("oenb.accept_req", r_req, 2);
        chk("oenb.accept_latency", r_lat, 4);
        model_upd(OP_RD, 32'h0BADF00D, 1'b0, 1'b0);
        chk_status("oenb");

`ifdef LA_NN_TIMEOUT_EN
        // READ never acknowledged: watchdog expires after 8 ISSUE cycles
        run_cmd(OP_RD, 16'h0077, 32'h0, 0, 32'h0, 1'b0, 0);
        chk("tmo.req_cycles", r_req, 8);
        chk("tmo.done_latency", r_lat, 10);
        model_upd(OP_RD, 32'h0, 1'b0, 1'b1);
        chk_status("tmo");
        run_cmd(OP_NOP, 16'h0, 32'h0, 1, 32'h0, 1'b0, 0);
        model_upd(OP_NOP, 32'h0, 1'b0, 1'b0);
        chk_status("tmo_clear");
`endif

        // randomized commands with spurious acks and occasional overrun toggles
        for (int it = 0; it < 40; it++) begin
            rop  = 2'($urandom_range(0, 3));
            rrd  = $urandom();
            rdly = int'($urandom_range(1, 6));
            rw   = (rop == OP_WR) || (rop == OP_RD);
            if ($urandom_range(0, 3) == 0) inj = rw ? int'($urandom_range(1, rdly)) : 1;
            else                           inj = 0;
            run_cmd(rop, 16'($urandom()), $urandom(), rdly, rrd, 1'b1, inj);
            chk($sformatf("rnd%0d.req_cycles", it), r_req, rw ? rdly : 0);
            chk($sformatf("rnd%0d.req_pulses", it), r_rises, rw ? 1 : 0);
            chk($sformatf("rnd%0d.start_cycles", it), r_start, (rop == OP_ST) ? 1 : 0);
            chk($sformatf("rnd%0d.done_latency", it), r_lat, rw ? rdly + 2 : 2);
            chk($sformatf("rnd%0d.req_attrs", it), 32'(r_attr), 32'd1);
            model_upd(rop, rrd, inj != 0, 1'b0);
            chk_status($sformatf("rnd%0d", it));
        end

        // reset in the middle of a transaction, with an ack pending across it
        la_data_in[49:48] = OP_RD;
        la_data_in[47:32] = 16'h0456;
        la_data_in[64]    = ~la_data_in[64];
        tick(); tick(); tick();
        chk("rst_mid.in_flight", 32'(nn_req), 32'd1);
        nn_ack   = 1'b1;
        nn_rdata = 32'hFFFFFFFF;
        resetb   = 1'b0;
        tick();
        chk128("rst_mid.la_data_out", la_data_out, 128'h0);
        chk("rst_mid.nn_req", 32'(nn_req), 32'd0);
        chk("rst_mid.nn_start", 32'(nn_start), 32'd0);
        chk("rst_mid.nn_we", 32'(nn_we), 32'd0);
        chk("rst_mid.nn_addr", 32'(nn_addr), 32'd0);
        chk("rst_mid.nn_wdata", nn_wdata, 32'd0);
        resetb = 1'b1;
        tick(); tick();
        nn_ack = 1'b0;
        chk128("rst_mid.ack_ignored", la_data_out, 128'h0);
        chk("rst_mid.req_after", 32'(nn_req), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
